neuromorphic_x1_ctrl: RTL and testbench

NEUROMORPHIC_X1_CTRL -- requirements
Module: neuromorphic_x1_ctrl

---
 rtl/neuromorphic_x1_ctrl_if.sv | 31 +++
 rtl/neuromorphic_x1_ctrl.sv | 136 +++++++++++++
 tb/tb_neuromorphic_x1_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/neuromorphic_x1_ctrl_if.sv
// Host request/response channel plus macro-side signals of the neuromorphic X1 controller.
// slave = controller view, master = host and macro environment view.
interface neuromorphic_x1_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        EN;
  logic        R_WB;
  logic [31:0] AD;
  logic [31:0] DI;
  logic [3:0]  SEL;
  logic        func_ack;
  logic [31:0] DO;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, req_sel, rsp_ready, func_ack, DO,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, EN, R_WB, AD, DI, SEL
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, req_sel, rsp_ready, func_ack, DO,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, EN, R_WB, AD, DI, SEL
  );
endinterface

// File: rtl/neuromorphic_x1_ctrl.sv
// Request/response bridge to the neuromorphic X1 macro (IDLE/BUSY/RESP/DRAIN).
// Optional BUSY watchdog enabled by defining NEUROMORPHIC_X1_CTRL_TIMEOUT_EN.
module neuromorphic_x1_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                         CLKin,
  input  logic                         RSTin,
  neuromorphic_x1_ctrl_if.slave        bus_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..65535");
  end

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        timeout_hit;

`ifdef NEUROMORPHIC_X1_CTRL_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (state_q == BUSY) && (cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus_if.req_valid && ready_q) begin
          rw_d    = bus_if.req_rw;
          addr_d  = bus_if.req_addr;
          wdata_d = bus_if.req_wdata;
          sel_d   = bus_if.req_sel;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A same-cycle acknowledge takes priority over the watchdog abort.
        if (bus_if.func_ack) begin
          rdata_d = rw_q ? bus_if.DO : '0;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus_if.rsp_ready) begin
          state_d = bus_if.func_ack ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (!bus_if.func_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is registered: low through reset and for one cycle after re-entering IDLE.
  assign ready_d = (state_q == IDLE) && (state_d == IDLE);

  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus_if.req_ready = ready_q;
  assign bus_if.rsp_valid = (state_q == RESP);
  assign bus_if.rsp_rdata = rdata_q;
  assign bus_if.rsp_err   = err_q;
  assign bus_if.EN        = (state_q == BUSY);
  assign bus_if.R_WB      = rw_q;
  assign bus_if.AD        = addr_q;
  assign bus_if.DI        = wdata_q;
  assign bus_if.SEL       = sel_q;

endmodule

// File: tb/tb_neuromorphic_x1_ctrl.sv
// Directed and randomized bench for neuromorphic_x1_ctrl against a transaction-level model.
// Optionally built with NEUROMORPHIC_X1_CTRL_TIMEOUT_EN to exercise the watchdog.
module tb_neuromorphic_x1_ctrl;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  neuromorphic_x1_ctrl_if bif ();

  neuromorphic_x1_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .CLKin  (clk),
    .RSTin  (rst),
    .bus_if (bif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int unsigned n = 0;
    while (bif.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/ready_wait"}, 32'(n < 20), 32'd1);
  endtask

  // One host transaction with the macro acknowledging on BUSY cycle ack_dly+1,
  // the host stalling rdy_dly cycles, and func_ack held drain_cyc cycles past the handshake.
  task automatic txn(input string tag, input logic rw, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] sel,
                     input int unsigned ack_dly, input logic [31:0] do_v,
                     input int unsigned rdy_dly, input int unsigned drain_cyc);
    logic [31:0] exp_rd;
    int unsigned en_cnt;
    exp_rd = rw ? do_v : 32'h0;
    bif.req_valid = 1'b1;
    bif.req_rw    = rw;
    bif.req_addr  = addr;
    bif.req_wdata = wdata;
    bif.req_sel   = sel;
    wait_ready(tag);
    @(negedge clk);
    bif.req_valid = 1'b0;
    bif.req_rw    = ~rw;
    bif.req_addr  = $urandom;
    bif.req_wdata = $urandom;
    bif.req_sel   = 4'($urandom);
    chk({tag, "/ready_busy"}, 32'(bif.req_ready), 32'd0);
    en_cnt = 0;
    for (int unsigned k = 0; k <= ack_dly; k++) begin
      if (k > 0) @(negedge clk);
      if (bif.EN === 1'b1) en_cnt++;
      chk({tag, "/AD"}, bif.AD, addr);
      chk({tag, "/DI"}, bif.DI, wdata);
      chk({tag, "/SEL"}, 32'(bif.SEL), 32'(sel));
      chk({tag, "/R_WB"}, 32'(bif.R_WB), 32'(rw));
      bif.func_ack = (k == ack_dly);
      bif.DO       = (k == ack_dly) ? do_v : $urandom;
    end
    chk({tag, "/en_cycles"}, en_cnt, ack_dly + 1);
    @(negedge clk);
    bif.func_ack = (drain_cyc > 0);
    bif.DO       = $urandom;
    chk({tag, "/en_off"}, 32'(bif.EN), 32'd0);
    for (int unsigned k = 0; k <= rdy_dly; k++) begin
      if (k > 0) @(negedge clk);
      chk({tag, "/rsp_valid"}, 32'(bif.rsp_valid), 32'd1);
      chk({tag, "/rdata"}, bif.rsp_rdata, exp_rd);
      chk({tag, "/err"}, 32'(bif.rsp_err), 32'd0);
      bif.rsp_ready = (k == rdy_dly);
    end
    @(negedge clk);
    bif.rsp_ready = 1'b0;
    for (int unsigned k = 0; k < drain_cyc; k++) begin
      chk({tag, "/drain_ready"}, 32'(bif.req_ready), 32'd0);
      chk({tag, "/drain_valid"}, 32'(bif.rsp_valid), 32'd0);
      if (k == drain_cyc - 1) bif.func_ack = 1'b0;
      @(negedge clk);
    end
    chk({tag, "/post_valid"}, 32'(bif.rsp_valid), 32'd0);
    chk({tag, "/post_en"}, 32'(bif.EN), 32'd0);
    chk({tag, "/keep_AD"}, bif.AD, addr);
    chk({tag, "/keep_DI"}, bif.DI, wdata);
    chk({tag, "/keep_SEL"}, 32'(bif.SEL), 32'(sel));
    chk({tag, "/keep_RWB"}, 32'(bif.R_WB), 32'(rw));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_q[$];
    int          acc[$];
    int          rsp_at[$];
    int unsigned n;
    logic [31:0] dv;

    bif.req_valid = 1'b0; bif.req_rw = 1'b0; bif.req_addr = '0; bif.req_wdata = '0;
    bif.req_sel = '0; bif.rsp_ready = 1'b0; bif.func_ack = 1'b0; bif.DO = '0;

    // Reset state
    @(negedge clk);
    chk("rst/EN", 32'(bif.EN), 32'd0);
    chk("rst/R_WB", 32'(bif.R_WB), 32'd1);
    chk("rst/AD", bif.AD, 32'h0);
    chk("rst/DI", bif.DI, 32'h0);
    chk("rst/SEL", 32'(bif.SEL), 32'h0);
    chk("rst/rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("rst/rdata", bif.rsp_rdata, 32'h0);
    chk("rst/err", 32'(bif.rsp_err), 32'd0);
    chk("rst/req_ready", 32'(bif.req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel/req_ready", 32'(bif.req_ready), 32'd1);

    // Directed write, read with host stall, stuck acknowledge
    txn("wr", 1'b0, 32'h0000_0010, 32'hA5A5_A5A5, 4'h3, 4, $urandom, 0, 0);
    txn("rd", 1'b1, 32'h0000_001F, $urandom, 4'h5, 1, 32'hDEAD_BEEF, 3, 0);
    txn("drain", 1'b0, 32'h0000_0020, 32'h1234_5678, 4'h9, 0, $urandom, 1, 4);

    // Back-to-back reads: one acceptance every 4 cycles, 3-edge latency
    wait_ready("b2b");
    bif.req_valid = 1'b1;
    bif.req_rw    = 1'b1;
    bif.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (bif.rsp_valid === 1'b1) begin
        rsp_at.push_back(cyc);
        if (exp_q.size() > 0) chk("b2b/rdata", bif.rsp_rdata, exp_q.pop_front());
      end
      if (bif.req_ready === 1'b1) acc.push_back(cyc);
      bif.func_ack = (bif.EN === 1'b1);
      if (bif.EN === 1'b1) begin
        dv = $urandom;
        bif.DO = dv;
        exp_q.push_back(dv);
      end
      bif.req_addr = $urandom;
      @(negedge clk);
    end
    bif.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bif.func_ack = (bif.EN === 1'b1);
      @(negedge clk);
    end
    bif.func_ack = 1'b0;
    bif.rsp_ready = 1'b0;
    chk("b2b/accepts", 32'(acc.size()), 32'd4);
    chk("b2b/responses", 32'(rsp_at.size()), 32'd4);
    for (int i = 1; i < acc.size(); i++) chk("b2b/spacing", 32'(acc[i] - acc[i-1]), 32'd4);
    // Edges from acceptance through the edge on which the host takes the response
    if (acc.size() > 0 && rsp_at.size() > 0) chk("b2b/latency", 32'(rsp_at[0] - acc[0] + 1), 32'd3);

    // Reset during the second BUSY cycle
    bif.req_valid = 1'b1; bif.req_rw = 1'b1; bif.req_addr = 32'hCAFE_0000;
    bif.req_wdata = 32'h5555_AAAA; bif.req_sel = 4'hF;
    wait_ready("rstbusy");
    @(negedge clk);
    bif.req_valid = 1'b0;
    @(negedge clk);
    chk("rstbusy/EN_before", 32'(bif.EN), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstbusy/EN", 32'(bif.EN), 32'd0);
    chk("rstbusy/AD", bif.AD, 32'h0);
    chk("rstbusy/R_WB", 32'(bif.R_WB), 32'd1);
    chk("rstbusy/req_ready", 32'(bif.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bif.func_ack = 1'b1;
    @(negedge clk);
    chk("rstbusy/ready_rel", 32'(bif.req_ready), 32'd1);
    chk("rstbusy/no_rsp", 32'(bif.rsp_valid), 32'd0);
    bif.func_ack = 1'b0;
    @(negedge clk);
    chk("rstbusy/no_rsp2", 32'(bif.rsp_valid), 32'd0);
    txn("after_rst", 1'b1, 32'h0000_0040, $urandom, 4'h2, 0, 32'h0BAD_F00D, 0, 0);

    // Missing acknowledge
    bif.req_valid = 1'b1; bif.req_rw = 1'b1; bif.req_addr = 32'h0000_0080;
    bif.req_wdata = $urandom; bif.req_sel = 4'h1;
    wait_ready("noack");
    @(negedge clk);
    bif.req_valid = 1'b0;
    bif.DO = 32'hFFFF_0001;
    n = 0;
    while (bif.EN === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
`ifdef NEUROMORPHIC_X1_CTRL_TIMEOUT_EN
    chk("timeout/en_cycles", n, TO);
    chk("timeout/rsp_valid", 32'(bif.rsp_valid), 32'd1);
    chk("timeout/err", 32'(bif.rsp_err), 32'd1);
    chk("timeout/rdata", bif.rsp_rdata, 32'h0);
`else
    chk("noto/en_held", n, 32'd20);
    bif.func_ack = 1'b1;
    @(negedge clk);
    bif.func_ack = 1'b0;
    chk("noto/rsp_valid", 32'(bif.rsp_valid), 32'd1);
    chk("noto/rdata", bif.rsp_rdata, 32'hFFFF_0001);
    chk("noto/err", 32'(bif.rsp_err), 32'd0);
`endif
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    bif.rsp_ready = 1'b0;

    // Randomized transactions
    for (int i = 0; i < 10; i++) begin
      txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), $urandom, $urandom,
          4'($urandom), $urandom_range(0, 4), $urandom, $urandom_range(0, 2),
          $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
